// File: rtl/alu_ctl_pkg.sv
// Shared types and constants for the ALU control sequencer.
package alu_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_LATCH,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    FC_ADD  = 3'b000,
    FC_INC  = 3'b001,
    FC_AND  = 3'b010,
    FC_OR   = 3'b011,
    FC_XOR  = 3'b100,
    FC_NOT  = 3'b101,
    FC_SHL  = 3'b110,
    FC_RSVD = 3'b111
  } fctn_e;

  localparam logic [3:0] ALU_OPCODE    = 4'b1000;
  localparam logic [2:0] RESERVED_CODE = 3'b111;

  // Width of the settle counter; holds SETTLE_CYCLES-1 for the full 1..15 range.
  localparam int TIMER_W = 4;

  // An instruction is legal when it carries the ALU opcode and a non-reserved code.
  function automatic logic isLegal(input logic [7:0] instrByte);
    return (instrByte[7:4] == ALU_OPCODE) && (instrByte[2:0] != RESERVED_CODE);
  endfunction

  // Only the arithmetic ops produce a meaningful carry out of the ALU.
  function automatic logic keepsCarry(input logic [2:0] code);
    return (code == FC_ADD) || (code == FC_INC);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long ALU inputs are held before latching.
module settle_timer
  import alu_ctl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_loadValue,
  input  logic               i_dec,
  output logic               o_expired
);

  logic [TIMER_W-1:0] r_count;

  // Load takes priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU instruction: drive operands, wait for settling, latch result and flags.
module alu_sequencer
  import alu_ctl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       alu_carry,
  output logic [2:0] fctn_code,
  output logic       sel_bc,
  output logic       ld_a,
  output logic       ld_d,
  output logic       ld_cond,
  output logic [7:0] result_q,
  output logic [2:0] cond_q,
  output logic       done,
  output logic       instr_err
);

  // SETTLE runs from SETTLE_CYCLES-1 down to 0, so the timer is loaded one below the cycle count.
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  state_e     r_state;
  logic       r_dest;
  logic [2:0] r_code;
  logic       r_ready;
  logic       r_selBc;
  logic [2:0] r_fctnCode;
  logic       r_ldA;
  logic       r_ldD;
  logic       r_ldCond;
  logic [7:0] r_resultQ;
  logic [2:0] r_condQ;
  logic       r_done;
  logic       r_instrErr;

  logic w_accept;
  logic w_timerLoad;
  logic w_timerDec;
  logic w_expired;

  assign w_accept    = instr_valid & r_ready;
  assign w_timerLoad = (r_state == ST_DRIVE);
  assign w_timerDec  = (r_state == ST_SETTLE);

  settle_timer uSettleTimer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_timerLoad),
    .i_loadValue (SETTLE_LOAD),
    .i_dec       (w_timerDec),
    .o_expired   (w_expired)
  );

  // Main FSM; every output is registered and set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dest     <= 1'b0;
      r_code     <= 3'b000;
      r_ready    <= 1'b0;
      r_selBc    <= 1'b0;
      r_fctnCode <= 3'b000;
      r_ldA      <= 1'b0;
      r_ldD      <= 1'b0;
      r_ldCond   <= 1'b0;
      r_resultQ  <= 8'h00;
      r_condQ    <= 3'b000;
      r_done     <= 1'b0;
      r_instrErr <= 1'b0;
    end else begin
      r_ldA      <= 1'b0;
      r_ldD      <= 1'b0;
      r_ldCond   <= 1'b0;
      r_done     <= 1'b0;
      r_instrErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (isLegal(instr)) begin
              r_dest     <= instr[3];
              r_code     <= instr[2:0];
              r_selBc    <= 1'b1;
              r_fctnCode <= instr[2:0];
              r_ready    <= 1'b0;
              r_state    <= ST_DRIVE;
            end else begin
              r_instrErr <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_expired) begin
            r_state  <= ST_LATCH;
            r_ldCond <= 1'b1;
            r_ldA    <= ~r_dest;
            r_ldD    <= r_dest;
          end
        end
        ST_LATCH: begin
          r_resultQ  <= alu_result;
          r_condQ    <= {alu_zero, alu_sign, alu_carry & keepsCarry(r_code)};
          r_selBc    <= 1'b0;
          r_fctnCode <= 3'b000;
          r_done     <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign sel_bc      = r_selBc;
  assign fctn_code   = r_fctnCode;
  assign ld_a        = r_ldA;
  assign ld_d        = r_ldD;
  assign ld_cond     = r_ldCond;
  assign result_q    = r_resultQ;
  assign cond_q      = r_condQ;
  assign done        = r_done;
  assign instr_err   = r_instrErr;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: three instances (SETTLE_CYCLES 2, 1, 15) share stimulus and are
// compared cycle by cycle against an expected timeline built from the latency rules.
module tb_alu_sequencer;

  localparam int NI   = 3;
  localparam int MAXP = 48;

  function automatic int settleOf(input int idx);
    case (idx)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vValid [NI];
  logic [7:0] vInstr;
  logic [7:0] vAluResult;
  logic       vZero;
  logic       vSign;
  logic       vCarry;

  logic       oReady [NI];
  logic [2:0] oFc    [NI];
  logic       oSel   [NI];
  logic       oLdA   [NI];
  logic       oLdD   [NI];
  logic       oLdC   [NI];
  logic [7:0] oRes   [NI];
  logic [2:0] oCond  [NI];
  logic       oDone  [NI];
  logic       oErr   [NI];

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gDut
    alu_sequencer #(.SETTLE_CYCLES(settleOf(g))) uDut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (vValid[g]),
      .instr_ready (oReady[g]),
      .instr       (vInstr),
      .alu_result  (vAluResult),
      .alu_zero    (vZero),
      .alu_sign    (vSign),
      .alu_carry   (vCarry),
      .fctn_code   (oFc[g]),
      .sel_bc      (oSel[g]),
      .ld_a        (oLdA[g]),
      .ld_d        (oLdD[g]),
      .ld_cond     (oLdC[g]),
      .result_q    (oRes[g]),
      .cond_q      (oCond[g]),
      .done        (oDone[g]),
      .instr_err   (oErr[g])
    );
  end

  int vectors   = 0;
  int errors    = 0;
  int ctxInst   = 0;
  int ctxPeriod = 0;
  int scLen     = 0;

  logic [7:0] curRes  [NI];
  logic [2:0] curCond [NI];

  // Stimulus per period: period n is driven at its falling edge and sampled at the rising edge ending it.
  logic       drvValid [NI][MAXP];
  logic [7:0] drvInstr [MAXP];
  logic [7:0] drvRes   [MAXP];
  logic [2:0] drvFlags [MAXP];

  // Expected outputs per instance and period.
  logic       expReady [NI][MAXP];
  logic       expSel   [NI][MAXP];
  logic [2:0] expFc    [NI][MAXP];
  logic       expLdA   [NI][MAXP];
  logic       expLdD   [NI][MAXP];
  logic       expLdC   [NI][MAXP];
  logic       expDone  [NI][MAXP];
  logic       expErr   [NI][MAXP];
  logic [7:0] expRes   [NI][MAXP];
  logic [2:0] expCond  [NI][MAXP];

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst=%0d period=%0d got=%h expected=%h", tag, ctxInst, ctxPeriod, obs, exp);
    end
  endtask

  // Fresh scenario: random or fixed ALU bus, nothing offered, every instance idle and holding its last result.
  task automatic newScenario(input int len, input bit fixedAlu, input logic [7:0] fRes, input logic [2:0] fFlags);
    scLen = len;
    for (int n = 0; n < MAXP; n++) begin
      drvInstr[n] = 8'($urandom);
      drvRes[n]   = fixedAlu ? fRes : 8'($urandom);
      drvFlags[n] = fixedAlu ? fFlags : 3'($urandom);
      for (int i = 0; i < NI; i++) begin
        drvValid[i][n] = 1'b0;
        expReady[i][n] = 1'b1;
        expSel[i][n]   = 1'b0;
        expFc[i][n]    = 3'b000;
        expLdA[i][n]   = 1'b0;
        expLdD[i][n]   = 1'b0;
        expLdC[i][n]   = 1'b0;
        expDone[i][n]  = 1'b0;
        expErr[i][n]   = 1'b0;
        expRes[i][n]   = curRes[i];
        expCond[i][n]  = curCond[i];
      end
    end
  endtask

  // Reference model: instance i accepts instruction ins at the edge ending period a.
  task automatic planAccept(input int i, input int a, input logic [7:0] ins);
    int         s;
    int         latchP;
    logic [2:0] code;
    logic       carryOk;
    s              = settleOf(i);
    code           = ins[2:0];
    drvValid[i][a] = 1'b1;
    drvInstr[a]    = ins;
    if (ins[7:4] == 4'h8 && code != 3'd7) begin
      latchP  = a + 2 + s;
      carryOk = (code == 3'd0) || (code == 3'd1);
      for (int n = a + 1; n <= a + 3 + s && n < MAXP; n++) begin
        expReady[i][n] = 1'b0;
        drvValid[i][n] = 1'($urandom);
        if (n <= latchP) begin
          expSel[i][n] = 1'b1;
          expFc[i][n]  = code;
        end
      end
      expLdA[i][latchP]    = ~ins[3];
      expLdD[i][latchP]    = ins[3];
      expLdC[i][latchP]    = 1'b1;
      expDone[i][latchP+1] = 1'b1;
      for (int n = latchP + 1; n < MAXP; n++) begin
        expRes[i][n]  = drvRes[latchP];
        expCond[i][n] = {drvFlags[latchP][2], drvFlags[latchP][1], drvFlags[latchP][0] & carryOk};
      end
    end else begin
      expErr[i][a+1] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < NI; i++) vValid[i] = drvValid[i][n];
    vInstr                 = drvInstr[n];
    vAluResult             = drvRes[n];
    {vZero, vSign, vCarry} = drvFlags[n];
  endtask

  task automatic checkPeriod(input int i, input int n);
    ctxInst = i;
    checkOutput("instr_ready", {7'd0, oReady[i]}, {7'd0, expReady[i][n]});
    checkOutput("sel_bc",      {7'd0, oSel[i]},   {7'd0, expSel[i][n]});
    checkOutput("fctn_code",   {5'd0, oFc[i]},    {5'd0, expFc[i][n]});
    checkOutput("ld_a",        {7'd0, oLdA[i]},   {7'd0, expLdA[i][n]});
    checkOutput("ld_d",        {7'd0, oLdD[i]},   {7'd0, expLdD[i][n]});
    checkOutput("ld_cond",     {7'd0, oLdC[i]},   {7'd0, expLdC[i][n]});
    checkOutput("done",        {7'd0, oDone[i]},  {7'd0, expDone[i][n]});
    checkOutput("instr_err",   {7'd0, oErr[i]},   {7'd0, expErr[i][n]});
    checkOutput("result_q",    oRes[i],           expRes[i][n]);
    checkOutput("cond_q",      {5'd0, oCond[i]},  {5'd0, expCond[i][n]});
  endtask

  task automatic checkReset(input int i);
    ctxInst = i;
    checkOutput("rst_ready",  {7'd0, oReady[i]}, 8'h00);
    checkOutput("rst_sel_bc", {7'd0, oSel[i]},   8'h00);
    checkOutput("rst_fctn",   {5'd0, oFc[i]},    8'h00);
    checkOutput("rst_ld_a",   {7'd0, oLdA[i]},   8'h00);
    checkOutput("rst_ld_d",   {7'd0, oLdD[i]},   8'h00);
    checkOutput("rst_ld_cond",{7'd0, oLdC[i]},   8'h00);
    checkOutput("rst_done",   {7'd0, oDone[i]},  8'h00);
    checkOutput("rst_err",    {7'd0, oErr[i]},   8'h00);
    checkOutput("rst_result", oRes[i],           8'h00);
    checkOutput("rst_cond",   {5'd0, oCond[i]},  8'h00);
  endtask

  task automatic runScenario();
    for (int n = 0; n < scLen; n++) begin
      @(negedge clk);
      ctxPeriod = n;
      for (int i = 0; i < NI; i++) checkPeriod(i, n);
      applyStimulus(n);
    end
    for (int i = 0; i < NI; i++) begin
      curRes[i]  = expRes[i][scLen-1];
      curCond[i] = expCond[i][scLen-1];
    end
  endtask

  task automatic holdReset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) vValid[i] = 1'b0;
    #1;
    ctxPeriod = -1;
    for (int i = 0; i < NI; i++) checkReset(i);
    @(negedge clk);
    for (int i = 0; i < NI; i++) checkReset(i);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      ctxInst = i;
      checkOutput("ready_after_release", {7'd0, oReady[i]}, 8'h00);
    end
    for (int i = 0; i < NI; i++) begin
      curRes[i]  = 8'h00;
      curCond[i] = 3'b000;
    end
  endtask

  function automatic logic [7:0] randomLegal();
    return {4'h8, 1'($urandom), 3'($urandom_range(0, 6))};
  endfunction

  initial begin
    logic [7:0] insA;
    logic [7:0] insB;
    int         acc;
    rst_n      = 1'b0;
    vInstr     = 8'h00;
    vAluResult = 8'h00;
    vZero      = 1'b0;
    vSign      = 1'b0;
    vCarry     = 1'b0;
    for (int i = 0; i < NI; i++) vValid[i] = 1'b0;
    repeat (2) @(negedge clk);
    holdReset();

    // ADD into A: zero and carry kept.
    newScenario(22, 1'b1, 8'h00, 3'b101);
    for (int i = 0; i < NI; i++) planAccept(i, 0, 8'h80);
    runScenario();

    // AND into D: carry masked.
    newScenario(22, 1'b1, 8'hF0, 3'b011);
    for (int i = 0; i < NI; i++) planAccept(i, 0, 8'h8A);
    runScenario();

    // Two illegal instructions back to back.
    newScenario(5, 1'b0, 8'h00, 3'b000);
    for (int i = 0; i < NI; i++) begin
      planAccept(i, 0, 8'h87);
      planAccept(i, 1, 8'h40);
    end
    runScenario();

    // Reset while every instance is in SETTLE, then a normal INC into A.
    newScenario(3, 1'b0, 8'h00, 3'b000);
    for (int i = 0; i < NI; i++) planAccept(i, 0, 8'h85);
    runScenario();
    #2;
    holdReset();
    newScenario(24, 1'b0, 8'h00, 3'b000);
    for (int i = 0; i < NI; i++) planAccept(i, 2, 8'h81);
    runScenario();

    // Valid held high across two instructions; the second is taken as soon as IDLE returns.
    newScenario(40, 1'b0, 8'h00, 3'b000);
    insA = randomLegal();
    insB = randomLegal();
    for (int i = 0; i < NI; i++) begin
      planAccept(i, 0, insA);
      planAccept(i, 4 + settleOf(i), insB);
      for (int n = 0; n <= 4 + settleOf(i); n++) drvValid[i][n] = 1'b1;
    end
    for (int n = 1; n < MAXP; n++) drvInstr[n] = insB;
    runScenario();

    // Randomized instructions, mostly legal, with random bus activity while busy.
    for (int k = 0; k < 25; k++) begin
      newScenario(22, 1'b0, 8'h00, 3'b000);
      insA = ($urandom_range(0, 3) != 0) ? randomLegal() : 8'($urandom);
      acc  = $urandom_range(0, 1);
      for (int i = 0; i < NI; i++) planAccept(i, acc, insA);
      runScenario();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of clocks ALU inputs are held before latch; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 instr_valid  in  1  instruction byte offered.
REQ-005 instr_ready  out  1  sequencer can accept an instruction.
REQ-006 instr  in  8  instruction; [7:4]=4'b1000 is an ALU op, [3]=dest (0=A, 1=D), [2:0]=function code.
REQ-007 alu_result  in  8  ALU result bus.
REQ-008 alu_zero, alu_sign, alu_carry  in  1 each  ALU flag outputs.
REQ-009 fctn_code  out  3  function code driven to the ALU decoder.
REQ-010 sel_bc  out  1  gates registers B and C onto the ALU inputs.
REQ-011 ld_a, ld_d  out  1 each  load strobes for registers A and D.
REQ-012 ld_cond  out  1  load strobe for the condition register.
REQ-013 result_q  out  8  last latched result.
REQ-014 cond_q  out  3  last latched flags {zero, sign, carry}.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 instr_err  out  1  one-cycle pulse when an illegal instruction is accepted.

Function
REQ-017 Function codes: 000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 reserved.
REQ-018 States: IDLE, DRIVE, SETTLE, LATCH, DONE.
REQ-019 instr_ready is 1 only in IDLE; a transfer occurs when instr_valid and instr_ready are both 1 on a rising edge.
REQ-020 Legal transfer (opcode 1000, code != 111): capture dest and code, then IDLE->DRIVE.
REQ-021 Illegal transfer (opcode != 1000, or code 111): pulse instr_err next cycle; stay IDLE; no strobes; result_q and cond_q unchanged.
REQ-022 DRIVE lasts one cycle with sel_bc=1 and fctn_code=the captured code, then moves to SETTLE.
REQ-023 SETTLE lasts exactly SETTLE_CYCLES cycles, counted down from SETTLE_CYCLES-1 to 0, with sel_bc and fctn_code held; at count 0 it moves to LATCH.
REQ-024 LATCH lasts one cycle with sel_bc held, ld_cond=1, ld_a=1 if dest=0 else ld_d=1, and captures alu_result and the flags into result_q and cond_q.
REQ-025 carry is captured from alu_carry only for ADD and INC; it is forced to 0 for every other code.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-027 Latency: with the accept edge at cycle 0, DRIVE is cycle 1, LATCH is cycle 2+SETTLE_CYCLES, done is cycle 3+SETTLE_CYCLES, and the earliest next accept is cycle 4+SETTLE_CYCLES.
REQ-028 Outside DRIVE, SETTLE and LATCH: sel_bc=0 and fctn_code=3'b000.
REQ-029 ld_a, ld_d, ld_cond, done and instr_err are each high for exactly one cycle per event; ld_a and ld_d are never high together.
REQ-030 instr_valid and instr changing while the sequencer is not in IDLE are ignored.

Reset
REQ-031 Reset asserted at any time, including mid-sequence, forces IDLE asynchronously and clears the settle counter.
REQ-032 Reset values: sel_bc=0, fctn_code=0, ld_a=0, ld_d=0, ld_cond=0, result_q=0, cond_q=0, done=0, instr_err=0.
REQ-033 Reset values (cont.): instr_ready=0 while reset is asserted; instr_ready=1 from the first clock after reset deassertion.
REQ-034 An instruction aborted by reset produces no strobe and no done pulse.

Structure
REQ-035 Package alu_ctl_pkg holds: the state enum, the function-code enum, the ALU opcode constant 4'b1000, and the reserved code 3'b111.
REQ-036 One sub-module settle_timer holds the loadable down-counter and asserts an expiry flag at 0; all remaining logic is in alu_sequencer.

Verification
REQ-037 Scenario ADD: SETTLE_CYCLES=2, instr=8'h80, alu_result=8'h00, zero=1, carry=1 -> ld_a at cycle 4, ld_d never, cond_q=3'b101, done at cycle 5.
REQ-038 Scenario AND: instr=8'h8A, alu_result=8'hF0, sign=1, carry=1 -> ld_d pulse, result_q=8'hF0, cond_q=3'b010 (carry masked).
REQ-039 Scenario illegal: instr=8'h87, then instr=8'h40 -> instr_err pulsed twice, no ld_* pulse, result_q and cond_q unchanged.
REQ-040 Scenario mid-sequence reset: rst_n low during SETTLE -> all outputs at reset values immediately, no done pulse; the next instr=8'h81 completes normally.
REQ-041 Scenario back-to-back: instr_valid held high with two instructions -> second accepted at cycle 4+SETTLE_CYCLES; instr_ready=0 throughout the first sequence.
REQ-042 Scenario SETTLE_CYCLES=1 and SETTLE_CYCLES=15 -> done at cycles 4 and 18 respectively.
